// File: rtl/vram_port_arbiter_pkg.sv
// Shared definitions for the display-RAM port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (2K x 8)
//   IDLE..ACK               : CPU handshake state encoding
//   gnt_sel_e               : which requester owns the RAM this cycle
package vram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;

    // CPU handshake states.
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_WAIT1 = 2'd1;
    localparam logic [1:0] RD_WAIT2 = 2'd2;
    localparam logic [1:0] ACK      = 2'd3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_CLR  = 2'd3
    } gnt_sel_e;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Requester-side bus of the display-RAM arbiter: video fetch port and
// CPU req/ack port.
//   master : requester view (drives requests, receives data/strobes)
//   slave  : arbiter view
interface vram_port_arbiter_if
    import vram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    // Video fetch: one-cycle strobe, fixed 3-cycle return.
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;

    // CPU: request held until the one-cycle ack.
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    modport master (
        output vid_req, vid_addr,
        input  vid_data, vid_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack
    );

    modport slave (
        input  vid_req, vid_addr,
        output vid_data, vid_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack
    );

endinterface

// File: rtl/vram_port_arbiter_clear_engine.sv
// Screen-clear engine: walks every RAM address once, writing a latched
// fill character whenever the arbiter grants it a spare cycle.
//   clk, rst_n          : clock, async active-low reset
//   clr_start, clr_char : start pulse and fill value (taken only when idle)
//   clr_gnt             : arbiter granted the current clr_addr this cycle
//   clr_req             : a write is pending (same as busy)
//   clr_addr, clr_data  : address / value to write when granted
//   clr_busy            : clear in progress
module vram_clear_engine
    import vram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter bit CLR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_char,
    input  logic              clr_gnt,
    output logic              clr_req,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data,
    output logic              clr_busy
);

    if (CLR_EN) begin : g_clr
        logic              busy_q, busy_d;
        logic [ADDR_W-1:0] cnt_q, cnt_d;
        logic [DATA_W-1:0] char_q, char_d;

        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        always_comb begin
            busy_d = busy_q;
            cnt_d  = cnt_q;
            char_d = char_q;
            if (!busy_q) begin
                if (clr_start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    char_d = clr_char;
                end
            end else if (clr_gnt) begin
                // Advance only on a granted write; the last address ends the run.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    busy_d = 1'b0;
                end
            end
        end

        // NOTE: state flops use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
                char_q <= '0;
            end else begin
                busy_q <= busy_d;
                cnt_q  <= cnt_d;
                char_q <= char_d;
            end
        end

        assign clr_req  = busy_q;
        assign clr_addr = cnt_q;
        assign clr_data = char_q;
        assign clr_busy = busy_q;
    end else begin : g_no_clr
        assign clr_req  = 1'b0;
        assign clr_addr = '0;
        assign clr_data = '0;
        assign clr_busy = 1'b0;
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Arbitrates one single-port synchronous display RAM between video fetch
// (hard priority, fixed 3-cycle latency), the CPU (req/ack) and the
// screen-clear engine (spare cycles only).
//   clk_pixel, reset_n      : pixel clock, async active-low reset
//   bus                     : video + CPU requester ports (slave modport)
//   clr_start/clr_char      : clear start pulse and fill value
//   clr_busy                : clear in progress
//   ram_addr/ram_we/ram_wdata : registered RAM command
//   ram_rdata               : RAM read data, one cycle after ram_addr
module vram_port_arbiter
    import vram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter bit CLR_EN = 1'b1
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    vram_port_arbiter_if.slave bus,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_char,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              clr_req;
    logic              clr_gnt;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

    gnt_sel_e          gnt_sel;
    logic              cpu_try;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              vid_p1_q, vid_p1_d;
    logic              vid_p2_q, vid_p2_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;

    logic [1:0]        cpu_state_q, cpu_state_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    vram_clear_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CLR_EN (CLR_EN)
    ) u_clear (
        .clk       (clk_pixel),
        .rst_n     (reset_n),
        .clr_start (clr_start),
        .clr_char  (clr_char),
        .clr_gnt   (clr_gnt),
        .clr_req   (clr_req),
        .clr_addr  (clr_addr),
        .clr_data  (clr_data),
        .clr_busy  (clr_busy)
    );

    // Fixed priority: video > CPU > clear. The CPU is considered only in
    // IDLE outside its ack cycle, so a held cpu_req cannot issue twice.
    always_comb begin
        cpu_try = (cpu_state_q == IDLE) && bus.cpu_req && !cpu_ack_q;
        if (bus.vid_req) begin
            gnt_sel = GNT_VID;
        end else if (cpu_try) begin
            gnt_sel = GNT_CPU;
        end else if (clr_req) begin
            gnt_sel = GNT_CLR;
        end else begin
            gnt_sel = GNT_NONE;
        end
    end

    assign clr_gnt = (gnt_sel == GNT_CLR);

    // RAM command register: an idle cycle holds the address and write data.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        unique case (gnt_sel)
            GNT_VID: ram_addr_d = bus.vid_addr;
            GNT_CPU: begin
                ram_addr_d  = bus.cpu_addr;
                ram_we_d    = bus.cpu_we;
                ram_wdata_d = bus.cpu_wdata;
            end
            GNT_CLR: begin
                ram_addr_d  = clr_addr;
                ram_we_d    = 1'b1;
                ram_wdata_d = clr_data;
            end
            GNT_NONE: ;
        endcase
    end

    // Video return pipeline: grant -> address out -> RAM data -> valid.
    always_comb begin
        vid_p1_d    = (gnt_sel == GNT_VID);
        vid_p2_d    = vid_p1_q;
        vid_valid_d = vid_p2_q;
        vid_data_d  = vid_p2_q ? ram_rdata : vid_data_q;
    end

    // CPU handshake. Writes ack straight from the grant; reads walk the
    // same 3-stage timing as video, so interleaved video grants are harmless.
    always_comb begin
        cpu_state_d = cpu_state_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        case (cpu_state_q)
            IDLE: begin
                if (gnt_sel == GNT_CPU) begin
                    if (bus.cpu_we) begin
                        cpu_ack_d = 1'b1;
                    end else begin
                        cpu_state_d = RD_WAIT1;
                    end
                end
            end
            RD_WAIT1: cpu_state_d = RD_WAIT2;
            RD_WAIT2: begin
                cpu_rdata_d = ram_rdata;
                cpu_ack_d   = 1'b1;
                cpu_state_d = ACK;
            end
            ACK:      cpu_state_d = IDLE;
            default:  cpu_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vid_p1_q    <= 1'b0;
            vid_p2_q    <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cpu_state_q <= IDLE;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vid_p1_q    <= vid_p1_d;
            vid_p2_q    <= vid_p2_d;
            vid_valid_q <= vid_valid_d;
            vid_data_q  <= vid_data_d;
            cpu_state_q <= cpu_state_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_we        = ram_we_q;
    assign ram_wdata     = ram_wdata_q;
    assign bus.vid_data  = vid_data_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural 2K x 8
// synchronous RAM attached to the ram_* port.
module tb_vram_port_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk_pixel = 1'b0;
    logic          reset_n;
    logic          clr_start;
    logic [DW-1:0] clr_char;
    logic          clr_busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    // Bench-side preload port into the RAM model.
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    always #20 clk_pixel = ~clk_pixel;

    vram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLR_EN(1'b1)) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .bus       (bus),
        .clr_start (clr_start),
        .clr_char  (clr_char),
        .clr_busy  (clr_busy),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always @(posedge clk_pixel) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    // Runs one CPU transaction; lat = cycles from request to ack, -1 on timeout.
    task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            output int lat, output logic [DW-1:0] rd);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        lat = -1;
        rd  = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.cpu_ack) begin
                lat = c;
                rd  = bus.cpu_rdata;
                break;
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        int            cnt_we, cnt_strobe, n_valid, n_ack, ack_cyc, first_vcyc, nwr, nbad, lat;
        logic [AW-1:0] addr5, last_addr;
        logic          last_we, done;
        logic [DW-1:0] vd [4];
        logic [DW-1:0] ack_data, rd, e;

        reset_n       = 1'b1;
        pl_en         = 1'b0;
        pl_addr       = '0;
        pl_data       = '0;
        clr_start     = 1'b0;
        clr_char      = '0;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        #5 reset_n = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_vid_valid", bus.vid_valid, 0);
        check("rst_vid_data",  bus.vid_data,  0);
        check("rst_cpu_ack",   bus.cpu_ack,   0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_clr_busy",  clr_busy,      0);
        check("rst_ram_addr",  ram_addr,      0);
        check("rst_ram_we",    ram_we,        0);
        check("rst_ram_wdata", ram_wdata,     0);
        reset_n = 1'b1;
        cnt_we = 0;
        cnt_strobe = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ram_we) cnt_we++;
            if (bus.vid_valid || bus.cpu_ack || clr_busy) cnt_strobe++;
        end
        check("idle_ram_we_count", cnt_we, 0);
        check("idle_strobe_count", cnt_strobe, 0);
        check("idle_ram_addr", ram_addr, 0);

        // ---- single video read ----
        preload(11'h123, 8'h41);
        bus.vid_req  = 1'b1;
        bus.vid_addr = 11'h123;
        tick();
        bus.vid_req = 1'b0;
        check("vid_t1_ram_addr", ram_addr, 11'h123);
        check("vid_t1_ram_we",   ram_we,   0);
        check("vid_t1_valid",    bus.vid_valid, 0);
        tick();
        check("vid_t2_valid", bus.vid_valid, 0);
        tick();
        check("vid_t3_valid", bus.vid_valid, 1);
        check("vid_t3_data",  bus.vid_data,  8'h41);
        tick();
        check("vid_t4_valid", bus.vid_valid, 0);
        check("vid_t4_hold",  bus.vid_data,  8'h41);

        // ---- CPU write then readback at top address ----
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 11'h7FF;
        bus.cpu_wdata = 8'h5A;
        tick();
        check("cw_ram_we",    ram_we,    1);
        check("cw_ram_addr",  ram_addr,  11'h7FF);
        check("cw_ram_wdata", ram_wdata, 8'h5A);
        check("cw_ack",       bus.cpu_ack, 1);
        bus.cpu_req = 1'b0;
        tick();
        check("cw_ack_drop", bus.cpu_ack, 0);
        check("cw_we_drop",  ram_we,      0);
        check("cw_mem",      mem[11'h7FF], 8'h5A);
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        tick();
        check("cr_t1_ram_addr", ram_addr, 11'h7FF);
        check("cr_t1_ram_we",   ram_we,   0);
        check("cr_t1_ack",      bus.cpu_ack, 0);
        tick();
        check("cr_t2_ack", bus.cpu_ack, 0);
        tick();
        check("cr_t3_ack",   bus.cpu_ack,   1);
        check("cr_t3_rdata", bus.cpu_rdata, 8'h5A);
        bus.cpu_req = 1'b0;
        tick();
        check("cr_t4_ack", bus.cpu_ack, 0);

        // ---- CPU read held against 4 back-to-back video fetches ----
        preload(11'h010, 8'hA0);
        preload(11'h011, 8'hA1);
        preload(11'h012, 8'hA2);
        preload(11'h013, 8'hA3);
        preload(11'h200, 8'hC3);
        n_valid = 0; n_ack = 0; ack_cyc = -1; first_vcyc = -1;
        ack_data = '0; addr5 = '0;
        for (int i = 0; i < 4; i++) vd[i] = '0;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 11'h200;
        for (int c = 0; c < 12; c++) begin
            bus.vid_req  = (c < 4);
            bus.vid_addr = 11'h010 + c[AW-1:0];
            tick();
            if (c + 1 == 5) addr5 = ram_addr;
            if (bus.vid_valid) begin
                if (first_vcyc < 0) first_vcyc = c + 1;
                if (n_valid < 4) vd[n_valid] = bus.vid_data;
                n_valid++;
            end
            if (bus.cpu_ack) begin
                n_ack++;
                ack_cyc  = c + 1;
                ack_data = bus.cpu_rdata;
                bus.cpu_req = 1'b0;
            end
        end
        bus.vid_req = 1'b0;
        check("mix_valid_count", n_valid, 4);
        check("mix_first_valid_cycle", first_vcyc, 3);
        for (int i = 0; i < 4; i++) begin
            e = 8'hA0 + 8'(i);
            check($sformatf("mix_vid_data%0d", i), vd[i], e);
        end
        check("mix_cpu_grant_addr", addr5, 11'h200);
        check("mix_ack_count", n_ack, 1);
        check("mix_ack_cycle", ack_cyc, 7);
        check("mix_ack_data",  ack_data, 8'hC3);

        // ---- screen clear with periodic video and an ignored restart ----
        clr_char  = 8'h20;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("clr_busy_rise", clr_busy, 1);
        nwr = 0; done = 1'b0; last_we = 1'b0; last_addr = '0;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            bus.vid_req  = (cyc % 8 == 0);
            bus.vid_addr = cyc[AW-1:0];
            if (cyc == 100) begin
                clr_start = 1'b1;
                clr_char  = 8'h55;
            end else begin
                clr_start = 1'b0;
            end
            tick();
            if (ram_we) nwr++;
            if (!clr_busy) begin
                done      = 1'b1;
                last_we   = ram_we;
                last_addr = ram_addr;
                break;
            end
        end
        bus.vid_req = 1'b0;
        clr_start   = 1'b0;
        check("clr_finished_in_budget", done, 1);
        check("clr_write_count", nwr, 2048);
        check("clr_last_we",   last_we,   1);
        check("clr_last_addr", last_addr, 11'h7FF);
        tick();
        tick();
        nbad = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            if (mem[i] !== 8'h20) nbad++;
        end
        check("clr_fill_mismatches", nbad, 0);
        check("clr_busy_stays_low", clr_busy, 0);

        // ---- reset during a CPU read in RD_WAIT1 ----
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 11'h005;
        tick();
        reset_n     = 1'b0;
        bus.cpu_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        cnt_strobe = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cpu_ack || bus.vid_valid) cnt_strobe++;
        end
        check("rstmid_no_strobe", cnt_strobe, 0);
        cpu_xfer(1'b0, 11'h005, 8'h00, lat, rd);
        check("post_rst_rd_lat",  lat, 3);
        check("post_rst_rd_data", rd,  8'h20);
        tick();
        cpu_xfer(1'b1, 11'h006, 8'h77, lat, rd);
        check("post_rst_wr_lat", lat, 1);
        tick();
        cpu_xfer(1'b0, 11'h006, 8'h00, lat, rd);
        check("post_rst_rd2_lat",  lat, 3);
        check("post_rst_rd2_data", rd,  8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
